// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_if
//  Purpose  : Bundles the fetch unit's ROM handshake and decoder-facing
//             signals into one interface.
//  Ports    : ROM side   - romAddr, romReq (to ROM); romData, romValid (from ROM)
//             Decoder    - stall, jmpEnable, branchEnable, jmpDir, branchDir
//                          (from decoder); instr, instrValid, pc (to decoder)
//  Modports : master - fetch unit view; slave - ROM/decoder environment view
//  Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
  parameter int unsigned PC_WIDTH    = 10,
  parameter int unsigned INSTR_WIDTH = 16
);
  // ROM read channel
  logic [PC_WIDTH-1:0]    romAddr;
  logic                   romReq;
  logic [INSTR_WIDTH-1:0] romData;
  logic                   romValid;

  // Decoder feedback
  logic                   stall;
  logic                   jmpEnable;
  logic                   branchEnable;
  logic [PC_WIDTH-1:0]    jmpDir;
  logic [5:0]             branchDir;

  // Decoder feed
  logic [INSTR_WIDTH-1:0] instr;
  logic                   instrValid;
  logic [PC_WIDTH-1:0]    pc;

  modport master (
    output romAddr, romReq, instr, instrValid, pc,
    input  romData, romValid, stall, jmpEnable, branchEnable, jmpDir, branchDir
  );

  modport slave (
    input  romAddr, romReq, instr, instrValid, pc,
    output romData, romValid, stall, jmpEnable, branchEnable, jmpDir, branchDir
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Program counter and instruction fetch. Requests one word from
//             program ROM, presents it to the decoder for one execute cycle,
//             then computes the next fetch address from the decoder's
//             jump/branch requests.
//  Ports    : clk   - system clock, rising edge
//             reset - asynchronous active-high reset
//             bus   - fetch_unit_if.master (ROM handshake + decoder signals)
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int unsigned             PC_WIDTH    = 10,
  parameter int unsigned             INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]     RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;

  logic [PC_WIDTH-1:0]    r_romAddr;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic                   r_instrValid;

  logic [PC_WIDTH-1:0]    w_pcInc;
  logic [PC_WIDTH-1:0]    w_branchOff;
  logic [PC_WIDTH-1:0]    w_nextAddr;
  logic                   w_accept;
  logic                   w_advance;

  // A ROM word is taken only while we are actually requesting; romValid in
  // any other state is ignored.
  assign w_accept  = (r_state == ST_FETCH) && bus.romValid;
  assign w_advance = (r_state == ST_EXEC)  && !bus.stall;

  // Branch offsets are relative to the instruction after the branch and wrap
  // modulo 2^PC_WIDTH.
  assign w_pcInc     = r_pc + PC_WIDTH'(1);
  assign w_branchOff = {{(PC_WIDTH-6){bus.branchDir[5]}}, bus.branchDir};

  // Jump has priority over branch.
  always_comb begin
    w_nextAddr = w_pcInc;
    if (bus.jmpEnable) begin
      w_nextAddr = bus.jmpDir;
    end else if (bus.branchEnable) begin
      w_nextAddr = w_pcInc + w_branchOff;
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_BOOT:  w_next_state = ST_FETCH;
      ST_FETCH: if (bus.romValid) w_next_state = ST_EXEC;
      ST_EXEC:  if (!bus.stall)   w_next_state = ST_FETCH;
      default:  w_next_state = ST_BOOT;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_romAddr    <= RESET_PC;
      r_pc         <= RESET_PC;
      r_instr      <= NOP_INSTR;
      r_instrValid <= 1'b0;
    end else if (w_accept) begin
      r_instr      <= bus.romData;
      r_pc         <= r_romAddr;
      r_instrValid <= 1'b1;
    end else if (w_advance) begin
      r_romAddr    <= w_nextAddr;
      r_instr      <= NOP_INSTR;
      r_instrValid <= 1'b0;
    end
  end

  // romReq is a pure decode of the state register, so romValid never reaches
  // an output combinationally.
  assign bus.romReq     = (r_state == ST_FETCH);
  assign bus.romAddr    = r_romAddr;
  assign bus.pc         = r_pc;
  assign bus.instr      = r_instr;
  assign bus.instrValid = r_instrValid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Directed self-checking bench for fetch_unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'hE000;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  fetch_unit_if #(.PC_WIDTH(10), .INSTR_WIDTH(16)) bus ();

  fetch_unit #(
    .PC_WIDTH    (10),
    .INSTR_WIDTH (16),
    .RESET_PC    (10'h000),
    .NOP_INSTR   (NOP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs and samples both settle 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ROM answers in the current cycle with the given word.
  task automatic serve(input logic [15:0] data);
    bus.romValid = 1'b1;
    bus.romData  = data;
    tick();
    bus.romValid = 1'b0;
    bus.romData  = 16'hDEAD;
  endtask

  // One non-stalled execute cycle with the given decoder feedback.
  task automatic exec_step(input logic jmp, input logic br,
                           input logic [9:0] jdir, input logic [5:0] bdir);
    bus.jmpEnable    = jmp;
    bus.branchEnable = br;
    bus.jmpDir       = jdir;
    bus.branchDir    = bdir;
    tick();
    bus.jmpEnable    = 1'b0;
    bus.branchEnable = 1'b0;
    bus.jmpDir       = '0;
    bus.branchDir    = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_checks++; if (bus.romReq !== 1'b0) begin n_fail++; $display("FAIL rst_romReq got=%b exp=0", bus.romReq); end
    n_checks++; if (bus.romAddr !== 10'h000) begin n_fail++; $display("FAIL rst_romAddr got=%h exp=000", bus.romAddr); end
    n_checks++; if (bus.pc !== 10'h000) begin n_fail++; $display("FAIL rst_pc got=%h exp=000", bus.pc); end
    n_checks++; if (bus.instr !== NOP) begin n_fail++; $display("FAIL rst_instr got=%h exp=%h", bus.instr, NOP); end
    n_checks++; if (bus.instrValid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", bus.instrValid); end
    reset = 1'b0;
    // BOOT cycle: no request even though ROM says valid
    bus.romValid = 1'b1;
    #1;
    n_checks++; if (bus.romReq !== 1'b0) begin n_fail++; $display("FAIL boot_romReq got=%b exp=0", bus.romReq); end
    tick();
    bus.romValid = 1'b0;
    n_checks++; if (bus.romReq !== 1'b1) begin n_fail++; $display("FAIL boot_to_fetch romReq got=%b exp=1", bus.romReq); end
    n_checks++; if (bus.instrValid !== 1'b0) begin n_fail++; $display("FAIL boot_valid_dropped got=%b exp=0", bus.instrValid); end
  endtask

  task automatic test_sequential();
    logic [15:0] w [4];
    w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333; w[3] = 16'h4444;
    for (int n = 0; n < 4; n++) begin
      n_checks++; if (bus.romReq !== 1'b1 || bus.romAddr !== 10'(n)) begin n_fail++; $display("FAIL seq_req[%0d] got req=%b addr=%h exp req=1 addr=%h", n, bus.romReq, bus.romAddr, 10'(n)); end
      n_checks++; if (bus.instr !== NOP || bus.instrValid !== 1'b0) begin n_fail++; $display("FAIL seq_nop[%0d] got instr=%h v=%b exp instr=%h v=0", n, bus.instr, bus.instrValid, NOP); end
      serve(w[n]);
      n_checks++; if (bus.instr !== w[n] || bus.pc !== 10'(n) || bus.instrValid !== 1'b1 || bus.romReq !== 1'b0) begin n_fail++; $display("FAIL seq_exec[%0d] got instr=%h pc=%h v=%b req=%b exp instr=%h pc=%h v=1 req=0", n, bus.instr, bus.pc, bus.instrValid, bus.romReq, w[n], 10'(n)); end
      if (n < 3) exec_step(1'b0, 1'b0, 10'h000, 6'h00);
    end
  endtask

  task automatic test_jump_priority();
    exec_step(1'b1, 1'b1, 10'h200, 6'h05);
    n_checks++; if (bus.romAddr !== 10'h200 || bus.romReq !== 1'b1) begin n_fail++; $display("FAIL jmp_prio got addr=%h req=%b exp addr=200 req=1", bus.romAddr, bus.romReq); end
    serve(16'hA5A5);
    n_checks++; if (bus.pc !== 10'h200 || bus.instr !== 16'hA5A5) begin n_fail++; $display("FAIL jmp_pc got pc=%h instr=%h exp pc=200 instr=a5a5", bus.pc, bus.instr); end
  endtask

  task automatic test_branch();
    exec_step(1'b1, 1'b0, 10'h005, 6'h00);
    serve(16'hB001);
    exec_step(1'b0, 1'b1, 10'h000, 6'b111100);
    n_checks++; if (bus.romAddr !== 10'h002) begin n_fail++; $display("FAIL br_neg got=%h exp=002", bus.romAddr); end
    serve(16'hB002);
    exec_step(1'b1, 1'b0, 10'h3F0, 6'h00);
    serve(16'hB003);
    exec_step(1'b0, 1'b1, 10'h000, 6'h1F);
    n_checks++; if (bus.romAddr !== 10'h010) begin n_fail++; $display("FAIL br_wrap got=%h exp=010", bus.romAddr); end
    serve(16'hB004);
    exec_step(1'b1, 1'b0, 10'h3FF, 6'h00);
    serve(16'hB005);
    exec_step(1'b0, 1'b0, 10'h000, 6'h00);
    n_checks++; if (bus.romAddr !== 10'h000) begin n_fail++; $display("FAIL seq_wrap got=%h exp=000", bus.romAddr); end
    serve(16'hB006);
    n_checks++; if (bus.pc !== 10'h000) begin n_fail++; $display("FAIL seq_wrap_pc got=%h exp=000", bus.pc); end
  endtask

  task automatic test_rom_delay();
    exec_step(1'b0, 1'b0, 10'h000, 6'h00);   // fetch from 0x001
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.romReq !== 1'b1 || bus.romAddr !== 10'h001 || bus.instr !== NOP || bus.instrValid !== 1'b0) begin n_fail++; $display("FAIL delay_wait[%0d] got req=%b addr=%h instr=%h v=%b exp req=1 addr=001 instr=%h v=0", i, bus.romReq, bus.romAddr, bus.instr, bus.instrValid, NOP); end
      bus.romData = 16'h0BAD;
      tick();
    end
    n_checks++; if (bus.instrValid !== 1'b0) begin n_fail++; $display("FAIL delay_pre got v=%b exp=0", bus.instrValid); end
    serve(16'hC0DE);
    n_checks++; if (bus.instr !== 16'hC0DE || bus.pc !== 10'h001 || bus.instrValid !== 1'b1) begin n_fail++; $display("FAIL delay_exec got instr=%h pc=%h v=%b exp instr=c0de pc=001 v=1", bus.instr, bus.pc, bus.instrValid); end
  endtask

  task automatic test_stall();
    bus.stall     = 1'b1;
    bus.jmpEnable = 1'b1;
    bus.jmpDir    = 10'h100;
    bus.romValid  = 1'b1;      // must be ignored outside FETCH
    bus.romData   = 16'h0BAD;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (bus.instr !== 16'hC0DE || bus.pc !== 10'h001 || bus.instrValid !== 1'b1 || bus.romReq !== 1'b0 || bus.romAddr !== 10'h001) begin n_fail++; $display("FAIL stall_hold[%0d] got instr=%h pc=%h v=%b req=%b addr=%h exp c0de 001 1 0 001", i, bus.instr, bus.pc, bus.instrValid, bus.romReq, bus.romAddr); end
    end
    bus.romValid = 1'b0;
    bus.stall    = 1'b0;
    tick();
    bus.jmpEnable = 1'b0;
    n_checks++; if (bus.romAddr !== 10'h100 || bus.romReq !== 1'b1 || bus.instr !== NOP || bus.instrValid !== 1'b0) begin n_fail++; $display("FAIL stall_release got addr=%h req=%b instr=%h v=%b exp 100 1 %h 0", bus.romAddr, bus.romReq, bus.instr, NOP, bus.instrValid); end
  endtask

  task automatic test_reset_mid_fetch();
    serve(16'hD100);
    exec_step(1'b1, 1'b0, 10'h040, 6'h00);
    tick();                     // waiting on ROM at 0x040
    n_checks++; if (bus.romAddr !== 10'h040 || bus.romReq !== 1'b1) begin n_fail++; $display("FAIL mid_wait got addr=%h req=%b exp 040 1", bus.romAddr, bus.romReq); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (bus.romReq !== 1'b0 || bus.romAddr !== 10'h000 || bus.pc !== 10'h000 || bus.instr !== NOP || bus.instrValid !== 1'b0) begin n_fail++; $display("FAIL async_rst got req=%b addr=%h pc=%h instr=%h v=%b exp 0 000 000 %h 0", bus.romReq, bus.romAddr, bus.pc, bus.instr, bus.instrValid, NOP); end
    tick();
    reset = 1'b0;
    bus.romValid = 1'b1;        // stale response during BOOT
    bus.romData  = 16'h0BAD;
    tick();
    bus.romValid = 1'b0;
    n_checks++; if (bus.romReq !== 1'b1 || bus.romAddr !== 10'h000 || bus.instrValid !== 1'b0 || bus.instr !== NOP) begin n_fail++; $display("FAIL post_rst_fetch got req=%b addr=%h v=%b instr=%h exp 1 000 0 %h", bus.romReq, bus.romAddr, bus.instrValid, bus.instr, NOP); end
    tick();
    n_checks++; if (bus.romReq !== 1'b1 || bus.instrValid !== 1'b0) begin n_fail++; $display("FAIL stale_dropped got req=%b v=%b exp 1 0", bus.romReq, bus.instrValid); end
    serve(16'h7777);
    n_checks++; if (bus.instr !== 16'h7777 || bus.pc !== 10'h000 || bus.instrValid !== 1'b1) begin n_fail++; $display("FAIL post_rst_exec got instr=%h pc=%h v=%b exp 7777 000 1", bus.instr, bus.pc, bus.instrValid); end
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    reset            = 1'b1;
    bus.romData      = 16'hDEAD;
    bus.romValid     = 1'b0;
    bus.stall        = 1'b0;
    bus.jmpEnable    = 1'b0;
    bus.branchEnable = 1'b0;
    bus.jmpDir       = '0;
    bus.branchDir    = '0;

    test_reset();
    test_sequential();
    test_jump_priority();
    test_branch();
    test_rom_delay();
    test_stall();
    test_reset_mid_fetch();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch and program-counter block that feeds the instruction decoder.
- Requests 16-bit instruction words from program ROM over a req/valid handshake, then presents each word to the decoder for one execute cycle.
- Samples the decoder's jmpEnable/branchEnable/jmpDir/branchDir in that same cycle to compute the next fetch address.
- Presents NOP_INSTR to the decoder while a fetch is in flight, so all decoder control outputs stay inert (wrEnable=0).

Parameters:
PC_WIDTH, 10, program address width (matches jmpDir/memDir width)
INSTR_WIDTH, 16, instruction word width
RESET_PC, 0, first fetch address after reset
NOP_INSTR, 16'h0000, word driven on instr when no valid instruction; top level overrides with the NOP encoding from def.v

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
romAddr  output  PC_WIDTH  ROM read address, registered
romReq  output  1  ROM read request, high in FETCH state only
romData  input  INSTR_WIDTH  ROM read data, qualified by romValid
romValid  input  1  ROM data valid; sampled only while romReq=1
stall  input  1  hold current instruction in EXEC (downstream not ready)
jmpEnable  input  1  absolute jump request from decoder
branchEnable  input  1  taken-branch request from decoder
jmpDir  input  PC_WIDTH  absolute jump target
branchDir  input  6  signed two's-complement branch offset
instr  output  INSTR_WIDTH  instruction to decoder input
instrValid  output  1  high while instr holds a fetched instruction (EXEC)
pc  output  PC_WIDTH  address of the instruction on instr

Behaviour:
- Reset (async, immediate): state=BOOT, romReq=0, romAddr=RESET_PC, pc=RESET_PC, instr=NOP_INSTR, instrValid=0.
- States: BOOT, FETCH, EXEC. All outputs registered or decoded from registered state; no combinational path from romValid to any output.
- BOOT: exactly one cycle after reset release, romReq=0, romValid ignored -> FETCH.
- FETCH:
  - romReq=1; romAddr held stable until accepted; instr=NOP_INSTR; instrValid=0.
  - On romValid=1: instr<=romData, pc<=romAddr, instrValid<=1 -> EXEC.
  - Otherwise remain in FETCH indefinitely.
  - Minimum fetch is 1 cycle (romValid in the first FETCH cycle), so peak throughput is 1 instruction per 2 cycles.
- EXEC, stall=1: hold instr/pc/instrValid; ignore jmpEnable/branchEnable; stay in EXEC.
- EXEC, stall=0: compute next address, romAddr<=next, instr<=NOP_INSTR, instrValid<=0 -> FETCH.
  - Priority 1, jmpEnable=1: next = jmpDir.
  - Priority 2, branchEnable=1: next = pc + 1 + sign_extend(branchDir), modulo 2^PC_WIDTH. Offset range is -32..+31, relative to the instruction after the branch.
  - Otherwise: next = pc + 1, modulo 2^PC_WIDTH (0x3FF wraps to 0x000).
  - jmpEnable and branchEnable both high: jump wins, branch ignored.
- romValid while romReq=0 (BOOT, EXEC): ignored, no state change.
- Reset mid-FETCH or mid-EXEC: in-flight request abandoned. After release, BOOT, then a fresh fetch from RESET_PC. A stale romValid during BOOT is dropped.
- romData is not checked for legality; unknown opcodes pass through to the decoder, which maps them to its default (NOP) controls.

Test Plan:
- Reset, ROM answers in 1 cycle with words W0..W3 at 0..3 -> romAddr 0,1,2,3 on alternate cycles; instr=Wn with pc=n and instrValid=1 every second cycle; instr=NOP_INSTR in between.
- JMP at pc=0x003 with jmpDir=0x200 and branchEnable=1 simultaneously -> next romAddr=0x200 (jump priority); next instr has pc=0x200.
- Branch taken at pc=0x005, branchDir=6'b111100 (-4) -> next romAddr=0x002. Branch at pc=0x3F0, branchDir=6'h1F -> romAddr=0x010 (wrap). Sequential fetch at pc=0x3FF -> romAddr=0x000.
- ROM delays romValid 3 cycles -> romReq high and romAddr stable all 3 cycles; instr=NOP_INSTR, instrValid=0 until the data cycle; EXEC entered the cycle after romValid.
- stall=1 for 2 EXEC cycles with jmpEnable=1, jmpDir=0x100 -> instr/pc held, romReq=0, no redirect. Stall released with jmpEnable=1 -> romAddr=0x100.
- reset pulsed during a FETCH wait at romAddr=0x040, romValid arrives in the BOOT cycle -> outputs return to reset values immediately; romValid dropped; first request after BOOT is romAddr=0x000.
